// File: rtl/mem_responder.sv
// ============================================================================
//  Module      : mem_responder
//  Description : Memory-side responder that completes one 16-bit read/write
//                per memread/memwrite request, routing to block RAM or I/O.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_responder #(
    parameter int          WAIT_CYCLES = 0,
    parameter logic [15:0] IO_BASE     = 16'hFF00,
    parameter int          IO_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic [15:0] ram_addr,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        io_req,
    output logic        io_we,
    output logic [15:0] io_addr,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata,
    input  logic        io_ack
);

    localparam int c_TCNT_W = $clog2(IO_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RAM_RD  = 3'd1,
        S_RAM_CAP = 3'd2,
        S_RAM_WR  = 3'd3,
        S_IO_REQ  = 3'd4,
        S_DONE    = 3'd5,
        S_RELEASE = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [15:0]           r_addr;
    logic [15:0]           r_wdata;
    logic                  r_write;
    logic [3:0]            r_wcnt;
    logic [c_TCNT_W-1:0]   r_tcnt;
    logic [15:0]           r_rdata;
    logic                  r_ready;
    logic                  r_err;
    logic                  w_req;
    logic                  w_is_io;
    logic                  w_wcnt_zero;
    logic                  w_tcnt_last;

    assign w_req       = memread | memwrite;
    assign w_is_io     = (addr >= IO_BASE);
    assign w_wcnt_zero = (r_wcnt == 4'd0);
    assign w_tcnt_last = (r_tcnt == c_TCNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and all combinational outputs; everything is zero in IDLE,
    // which makes the outputs drop as soon as reset forces IDLE.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = 16'h0000;
        ram_wdata    = 16'h0000;
        io_req       = 1'b0;
        io_we        = 1'b0;
        io_addr      = 16'h0000;
        io_wdata     = 16'h0000;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_req) begin
                    if (w_is_io) begin
                        w_next_state = S_IO_REQ;
                    end else if (memwrite) begin
                        w_next_state = S_RAM_WR;
                    end else begin
                        w_next_state = S_RAM_RD;
                    end
                end
            end
            S_RAM_RD: begin
                ram_en   = 1'b1;
                ram_addr = r_addr;
                if (w_wcnt_zero) begin
                    w_next_state = S_RAM_CAP;
                end
            end
            S_RAM_CAP: begin
                w_next_state = S_DONE;
            end
            S_RAM_WR: begin
                ram_addr  = r_addr;
                ram_wdata = r_wdata;
                ram_we    = w_wcnt_zero;
                if (w_wcnt_zero) begin
                    w_next_state = S_DONE;
                end
            end
            S_IO_REQ: begin
                io_req   = 1'b1;
                io_we    = r_write;
                io_addr  = r_addr;
                io_wdata = r_wdata;
                if (io_ack || w_tcnt_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_RELEASE;
            end
            S_RELEASE: begin
                if (!w_req) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
            r_write <= 1'b0;
            r_wcnt  <= 4'd0;
            r_tcnt  <= '0;
            r_rdata <= 16'h0000;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // Registered pulse: the ready cycle follows the DONE state.
            r_ready <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_write <= memwrite;
                        r_wcnt  <= 4'(WAIT_CYCLES);
                        r_tcnt  <= c_TCNT_W'(IO_TIMEOUT);
                        r_err   <= 1'b0;
                    end
                end
                S_RAM_RD, S_RAM_WR: begin
                    if (!w_wcnt_zero) begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                S_RAM_CAP: begin
                    r_rdata <= ram_rdata;
                end
                S_IO_REQ: begin
                    // Ack takes priority over a timeout on the same cycle.
                    if (io_ack) begin
                        if (!r_write) begin
                            r_rdata <= io_rdata;
                        end
                    end else if (w_tcnt_last) begin
                        r_err <= 1'b1;
                        if (!r_write) begin
                            r_rdata <= 16'hFFFF;
                        end
                    end else begin
                        r_tcnt <= r_tcnt - c_TCNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Scoreboard bench for mem_responder with a RAM model and
//                an I/O responder driven from the scenario tasks.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_responder;

    localparam int          WAIT = 2;
    localparam int          TMO  = 8;
    localparam logic [15:0] IOB  = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;
    logic [15:0] ram_addr;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0000;
    logic        io_req;
    logic        io_we;
    logic [15:0] io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata = 16'h0000;
    logic        io_ack = 1'b0;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int en_cnt = 0;
    int rdy_cnt = 0;
    int ioreq_cnt = 0;
    logic [15:0] last_we_addr = 16'h0000;
    logic [15:0] last_we_data = 16'h0000;
    logic [15:0] exp_q[$];
    logic [15:0] model_rdata = 16'h0000;
    logic [15:0] mem [0:255];

    mem_responder #(
        .WAIT_CYCLES (WAIT),
        .IO_BASE     (IOB),
        .IO_TIMEOUT  (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memread   (memread),
        .memwrite  (memwrite),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .busy      (busy),
        .err       (err),
        .ram_addr  (ram_addr),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ack    (io_ack)
    );

    always #5 clk = ~clk;

    // Synchronous block RAM: read data appears the cycle after ram_en.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
        if (ram_en) ram_rdata <= mem[ram_addr[7:0]];
    end

    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt       = we_cnt + 1;
            last_we_addr = ram_addr;
            last_we_data = ram_wdata;
        end
        if (ram_en) en_cnt = en_cnt + 1;
        if (ready)  rdy_cnt = rdy_cnt + 1;
        if (io_req) ioreq_cnt = ioreq_cnt + 1;
    end

    // Present a request, let the sampling edge pass, then scramble addr/wdata.
    task automatic issue(input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        memread  = rd;
        memwrite = wr;
        addr     = a;
        wdata    = d;
        @(posedge clk);
        #1;
        addr  = ~a;
        wdata = ~d;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (ready) return;
        end
        checks++;
        errors++;
        $display("FAIL ready_timeout: no ready within %0d cycles", n);
    endtask

    task automatic release_req;
        @(negedge clk);
        memread  = 1'b0;
        memwrite = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rdata, ready, busy, err} !== 19'h0) begin
            errors++;
            $display("FAIL reset_status: rdata=%h ready=%b busy=%b err=%b expected all 0", rdata, ready, busy, err);
        end
        checks++;
        if ({ram_addr, ram_en, ram_we, ram_wdata, io_req, io_we, io_addr, io_wdata} !== 68'h0) begin
            errors++;
            $display("FAIL reset_ports: ram_en=%b ram_we=%b ram_addr=%h io_req=%b io_addr=%h expected all 0",
                     ram_en, ram_we, ram_addr, io_req, io_addr);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_ram_write;
        int n;
        int we0;
        logic [15:0] got;
        we0 = we_cnt;
        issue(1'b0, 1'b1, 16'h0020, 16'hBEEF);
        exp_q.push_back(model_rdata);
        wait_ready(n);
        checks++;
        if (n !== WAIT + 2) begin
            errors++;
            $display("FAIL wr_latency: got %0d expected %0d", n, WAIT + 2);
        end
        got = exp_q.pop_front();
        checks++;
        if (rdata !== got) begin
            errors++;
            $display("FAIL wr_rdata_kept: rdata=%h expected %h", rdata, got);
        end
        checks++;
        if (we_cnt - we0 !== 1 || last_we_addr !== 16'h0020 || last_we_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr_pulse: pulses=%0d addr=%h data=%h expected 1 0020 BEEF",
                     we_cnt - we0, last_we_addr, last_we_data);
        end
        release_req();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_release: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_ram_read;
        int n;
        int en0;
        logic [15:0] got;
        issue(1'b0, 1'b1, 16'h0010, 16'h1234);
        wait_ready(n);
        release_req();
        en0 = en_cnt;
        issue(1'b1, 1'b0, 16'h0010, 16'h0000);
        exp_q.push_back(16'h1234);
        wait_ready(n);
        checks++;
        if (n !== WAIT + 3) begin
            errors++;
            $display("FAIL rd_latency: got %0d expected %0d", n, WAIT + 3);
        end
        checks++;
        if (en_cnt - en0 !== WAIT + 1) begin
            errors++;
            $display("FAIL rd_en_cycles: got %0d expected %0d", en_cnt - en0, WAIT + 1);
        end
        got = exp_q.pop_front();
        checks++;
        if (rdata !== got) begin
            errors++;
            $display("FAIL rd_data: rdata=%h expected %h", rdata, got);
        end
        model_rdata = got;
        release_req();
        issue(1'b1, 1'b0, 16'h0020, 16'h0000);
        exp_q.push_back(16'hBEEF);
        wait_ready(n);
        got = exp_q.pop_front();
        checks++;
        if (rdata !== got) begin
            errors++;
            $display("FAIL rd_readback: rdata=%h expected %h", rdata, got);
        end
        model_rdata = got;
        release_req();
    endtask

    task automatic test_io;
        int n;
        int io0;
        logic [15:0] got;
        issue(1'b1, 1'b0, 16'hFF04, 16'h0000);
        exp_q.push_back(16'h00A5);
        checks++;
        if (io_req !== 1'b1 || io_we !== 1'b0 || io_addr !== 16'hFF04 || busy !== 1'b1) begin
            errors++;
            $display("FAIL io_rd_req: io_req=%b io_we=%b io_addr=%h expected 1 0 FF04", io_req, io_we, io_addr);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        io_ack   = 1'b1;
        io_rdata = 16'h00A5;
        @(posedge clk);
        #1;
        io_ack   = 1'b0;
        io_rdata = 16'h0000;
        checks++;
        if (io_req !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL io_ack_drop: io_req=%b ready=%b expected 0 0", io_req, ready);
        end
        wait_ready(n);
        got = exp_q.pop_front();
        checks++;
        if (n !== 1 || rdata !== got || err !== 1'b0) begin
            errors++;
            $display("FAIL io_rd_data: lat=%0d rdata=%h err=%b expected 1 %h 0", n, rdata, err, got);
        end
        model_rdata = got;
        release_req();
        // I/O write: rdata must be left alone
        issue(1'b0, 1'b1, 16'hFF10, 16'hC0DE);
        exp_q.push_back(model_rdata);
        checks++;
        if (io_req !== 1'b1 || io_we !== 1'b1 || io_wdata !== 16'hC0DE || io_addr !== 16'hFF10) begin
            errors++;
            $display("FAIL io_wr_req: io_req=%b io_we=%b io_wdata=%h io_addr=%h expected 1 1 C0DE FF10",
                     io_req, io_we, io_wdata, io_addr);
        end
        @(negedge clk);
        io_ack = 1'b1;
        @(posedge clk);
        #1;
        io_ack = 1'b0;
        wait_ready(n);
        got = exp_q.pop_front();
        checks++;
        if (rdata !== got) begin
            errors++;
            $display("FAIL io_wr_rdata_kept: rdata=%h expected %h", rdata, got);
        end
        release_req();
        // Just below the I/O window goes to RAM
        io0 = ioreq_cnt;
        issue(1'b0, 1'b1, 16'hFEFF, 16'h7777);
        wait_ready(n);
        release_req();
        issue(1'b1, 1'b0, 16'hFEFF, 16'h0000);
        exp_q.push_back(16'h7777);
        wait_ready(n);
        got = exp_q.pop_front();
        checks++;
        if (rdata !== got || n !== WAIT + 3 || ioreq_cnt !== io0) begin
            errors++;
            $display("FAIL io_boundary: rdata=%h lat=%0d io_req_cycles=%0d expected %h %0d 0",
                     rdata, n, ioreq_cnt - io0, got, WAIT + 3);
        end
        model_rdata = got;
        release_req();
    endtask

    task automatic test_io_timeout;
        int n;
        int cnt;
        logic [15:0] got;
        issue(1'b1, 1'b0, IOB, 16'h0000);
        exp_q.push_back(16'hFFFF);
        cnt = 0;
        while (io_req === 1'b1 && cnt < 20) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (cnt !== TMO) begin
            errors++;
            $display("FAIL tmo_req_cycles: got %0d expected %0d", cnt, TMO);
        end
        wait_ready(n);
        got = exp_q.pop_front();
        checks++;
        if (n !== 1 || rdata !== got || err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_result: lat=%0d rdata=%h err=%b expected 1 %h 1", n, rdata, err, got);
        end
        model_rdata = got;
        release_req();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: err=%b expected 1", err);
        end
        issue(1'b1, 1'b0, 16'h0010, 16'h0000);
        exp_q.push_back(16'h1234);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_err_clear: err=%b expected 0", err);
        end
        wait_ready(n);
        got = exp_q.pop_front();
        checks++;
        if (rdata !== got) begin
            errors++;
            $display("FAIL tmo_next_rd: rdata=%h expected %h", rdata, got);
        end
        model_rdata = got;
        release_req();
    endtask

    task automatic test_back_to_back;
        int n;
        int we0;
        int rdy0;
        logic [15:0] got;
        we0  = we_cnt;
        rdy0 = rdy_cnt;
        issue(1'b1, 1'b1, 16'h0030, 16'h5A5A);
        exp_q.push_back(model_rdata);
        wait_ready(n);
        got = exp_q.pop_front();
        checks++;
        if (n !== WAIT + 2 || rdata !== got) begin
            errors++;
            $display("FAIL dual_write: lat=%0d rdata=%h expected %0d %h", n, rdata, WAIT + 2, got);
        end
        repeat (10 - n) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || we_cnt - we0 !== 1 || rdy_cnt - rdy0 !== 1) begin
            errors++;
            $display("FAIL dual_hold: busy=%b writes=%0d readies=%0d expected 1 1 1",
                     busy, we_cnt - we0, rdy_cnt - rdy0);
        end
        @(negedge clk);
        memread = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL dual_one_strobe: busy=%b expected 1", busy);
        end
        @(negedge clk);
        memwrite = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || we_cnt - we0 !== 1) begin
            errors++;
            $display("FAIL dual_idle: busy=%b writes=%0d expected 0 1", busy, we_cnt - we0);
        end
        issue(1'b1, 1'b0, 16'h0030, 16'h0000);
        exp_q.push_back(16'h5A5A);
        wait_ready(n);
        got = exp_q.pop_front();
        checks++;
        if (rdata !== got) begin
            errors++;
            $display("FAIL dual_readback: rdata=%h expected %h", rdata, got);
        end
        model_rdata = got;
        release_req();
    endtask

    task automatic test_reset_abort;
        int n;
        int we0;
        logic [15:0] got;
        issue(1'b0, 1'b1, 16'h0040, 16'h2222);
        wait_ready(n);
        release_req();
        we0 = we_cnt;
        issue(1'b0, 1'b1, 16'h0040, 16'h9999);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, ram_we, ram_addr, ram_wdata, rdata, ready} !== 51'h0) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b ram_we=%b ram_addr=%h rdata=%h ready=%b expected all 0",
                     busy, ram_we, ram_addr, rdata, ready);
        end
        memwrite = 1'b0;
        model_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (we_cnt !== we0) begin
            errors++;
            $display("FAIL abort_no_write: writes=%0d expected 0", we_cnt - we0);
        end
        issue(1'b1, 1'b0, 16'h0040, 16'h0000);
        exp_q.push_back(16'h2222);
        wait_ready(n);
        got = exp_q.pop_front();
        checks++;
        if (rdata !== got || n !== WAIT + 3) begin
            errors++;
            $display("FAIL abort_recover: rdata=%h lat=%0d expected %h %0d", rdata, n, got, WAIT + 3);
        end
        model_rdata = got;
        release_req();
    endtask

    initial begin
        test_reset();
        test_ram_write();
        test_ram_read();
        test_io();
        test_io_timeout();
        test_back_to_back();
        test_reset_abort();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
